// File: rtl/rc4_pkg.sv
// ----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-search datapath:
//   - MODE_* : phase-select codes driven onto the RAM controller's mode input.
//   - search_state_t : state encoding of the key-search sequencer.
//   - state_mode / state_busy : decodes used to build the registered outputs.
// ----------------------------------------------------------------------------
package rc4_pkg;

    localparam logic [5:0] MODE_IDLE    = 6'b000_000;
    localparam logic [5:0] MODE_INIT    = 6'b001_000;
    localparam logic [5:0] MODE_SHUFFLE = 6'b010_000;
    localparam logic [5:0] MODE_DECRYPT = 6'b011_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_INIT,
        S_SHUFFLE,
        S_DECRYPT,
        S_FOUND,
        S_EXHAUSTED,
        S_ERROR
    } search_state_t;

    // Phase-select code a given state presents to the RAM controller.
    function automatic logic [5:0] state_mode(search_state_t s);
        case (s)
            S_INIT:    return MODE_INIT;
            S_SHUFFLE: return MODE_SHUFFLE;
            S_DECRYPT: return MODE_DECRYPT;
            default:   return MODE_IDLE;
        endcase
    endfunction

    // A search is in progress in the gap and in every phase state.
    function automatic logic state_busy(search_state_t s);
        return s inside {S_GAP, S_INIT, S_SHUFFLE, S_DECRYPT};
    endfunction

endpackage

// File: rtl/phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Cleared, saturating cycle counter. While clear_i is low it counts up once per
// cycle and stops at LIMIT-1; expired_o is high on the cycle the count sits at
// LIMIT-1, i.e. the LIMIT-th cycle after clear_i drops.
// Ports:
//   clk       : clock
//   reset     : asynchronous, active-high
//   clear_i   : hold the count at zero
//   expired_o : count has reached LIMIT-1 (and clear_i is low)
// ----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned LIMIT = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = !clear_i && (count_q == LAST);

endmodule

// File: rtl/key_search_controller.sv
// ----------------------------------------------------------------------------
// key_search_controller
// Walks a key range and, for each candidate, sequences the RAM controller
// through S-RAM init, shuffle and decrypt. Stops on the first decrypt success,
// when the next key would leave the KEY_BITS range, or when a phase overruns
// TIMEOUT cycles. A one-cycle GAP separates phases so each device sees its
// start deassert.
// Ports:
//   clk, reset   : clock; asynchronous active-high reset
//   start        : pulse, begins a search (only when not busy)
//   abort        : synchronous return to IDLE, highest priority
//   finish_bus   : per-device done levels (0 init, 1 shuffle, 2 decrypt)
//   success      : decryptor hit, qualified by finish_bus[2]
//   mode         : phase select to the RAM controller
//   key          : current candidate, key[0] is the most significant byte
//   attempts     : candidates whose decrypt has completed
//   busy         : search in progress
//   found, exhausted, timeout_err : sticky terminal flags
// All outputs are registered.
// ----------------------------------------------------------------------------
module key_search_controller
    import rc4_pkg::*;
#(
    parameter int unsigned RAM_WIDTH   = 8,
    parameter int unsigned KEY_LENGTH  = 3,
    parameter int unsigned NUM_DEVICES = 3,
    parameter int unsigned KEY_BITS    = 22,
    parameter int unsigned KEY_START   = 0,
    parameter int unsigned KEY_STRIDE  = 1,
    parameter int unsigned TIMEOUT     = 8192
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [NUM_DEVICES-1:0]               finish_bus,
    input  logic                                 success,
    output logic [5:0]                           mode,
    output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
    output logic [KEY_BITS-1:0]                  attempts,
    output logic                                 busy,
    output logic                                 found,
    output logic                                 exhausted,
    output logic                                 timeout_err
);

    localparam int unsigned KW = KEY_LENGTH * RAM_WIDTH;

    search_state_t         state_q, state_d;
    search_state_t         next_phase_q, next_phase_d;
    logic [KW-1:0]         k_q, k_d;
    logic [KEY_BITS-1:0]   attempts_q, attempts_d;
    logic                  found_q, found_d;
    logic                  exhausted_q, exhausted_d;
    logic                  timeout_q, timeout_d;
    logic [5:0]            mode_q;
    logic                  busy_q;

    logic                  timer_clear;
    logic                  timer_expired;
    logic [KEY_BITS:0]     k_sum;

    // The counter is cleared outside the phase states; every phase is entered
    // from GAP, so it always starts a phase at zero.
    assign timer_clear = !(state_q inside {S_INIT, S_SHUFFLE, S_DECRYPT});

    phase_timer #(
        .LIMIT (TIMEOUT)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timer_clear),
        .expired_o (timer_expired)
    );

    // One extra bit so the range check sees the carry instead of wrapping.
    assign k_sum = {1'b0, k_q[KEY_BITS-1:0]} + (KEY_BITS + 1)'(KEY_STRIDE);

    always_comb begin
        state_d      = state_q;
        next_phase_d = next_phase_q;
        k_d          = k_q;
        attempts_d   = attempts_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        timeout_d    = timeout_q;

        if (abort) begin
            state_d     = S_IDLE;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
                    if (start) begin
                        state_d      = S_GAP;
                        next_phase_d = S_INIT;
                        k_d          = KW'(KEY_START);
                        attempts_d   = '0;
                        found_d      = 1'b0;
                        exhausted_d  = 1'b0;
                        timeout_d    = 1'b0;
                    end
                end
                S_GAP: state_d = next_phase_q;
                // In each phase the own finish bit is tested before the
                // timer, so a finish on the expiry cycle still advances.
                S_INIT: begin
                    if (finish_bus[0]) begin
                        state_d      = S_GAP;
                        next_phase_d = S_SHUFFLE;
                    end else if (timer_expired) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end
                end
                S_SHUFFLE: begin
                    if (finish_bus[1]) begin
                        state_d      = S_GAP;
                        next_phase_d = S_DECRYPT;
                    end else if (timer_expired) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end
                end
                S_DECRYPT: begin
                    if (finish_bus[2]) begin
                        attempts_d = attempts_q + KEY_BITS'(1);
                        if (success) begin
                            state_d = S_FOUND;
                            found_d = 1'b1;
                        end else if (k_sum[KEY_BITS]) begin
                            state_d     = S_EXHAUSTED;
                            exhausted_d = 1'b1;
                        end else begin
                            k_d          = KW'(k_sum[KEY_BITS-1:0]);
                            state_d      = S_GAP;
                            next_phase_d = S_INIT;
                        end
                    end else if (timer_expired) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            next_phase_q <= S_INIT;
            k_q          <= '0;
            attempts_q   <= '0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
            mode_q       <= MODE_IDLE;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_phase_q <= next_phase_d;
            k_q          <= k_d;
            attempts_q   <= attempts_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            timeout_q    <= timeout_d;
            // Decoded from the next state so mode/busy line up with state_q.
            mode_q       <= state_mode(state_d);
            busy_q       <= state_busy(state_d);
        end
    end

    // key[0] carries the most significant byte of K.
    always_comb begin
        for (int i = 0; i < KEY_LENGTH; i++) begin
            key[i] = k_q[(KEY_LENGTH - 1 - i) * RAM_WIDTH +: RAM_WIDTH];
        end
    end

    assign mode        = mode_q;
    assign attempts    = attempts_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_key_search_controller.sv
// ----------------------------------------------------------------------------
// tb_key_search_controller
// Two controller instances share the device-side inputs: A (KEY_START 0,
// stride 1, 22 key bits, TIMEOUT 32) and B (KEY_START 1, stride 4, 4 key bits,
// TIMEOUT 16). 'sel' picks which one receives start and is observed.
// A device model reacts to mode with a programmable latency, with random
// stale finish bits and random success when it is not qualified. A reference
// model predicts the per-cycle {busy, mode} trace and the final outcome.
// ----------------------------------------------------------------------------
module tb_key_search_controller;

    localparam logic [5:0] M_IDLE = 6'b000_000;
    localparam logic [5:0] M_INIT = 6'b001_000;
    localparam logic [5:0] M_SHUF = 6'b010_000;
    localparam logic [5:0] M_DEC  = 6'b011_000;

    logic       clk = 1'b0;
    logic       reset, start, abort, success, sel;
    logic [2:0] finish_bus;

    logic [5:0]       mode_a, mode_b;
    logic [2:0][7:0]  key_a, key_b;
    logic [21:0]      att_a;
    logic [3:0]       att_b;
    logic             busy_a, busy_b, found_a, found_b, exh_a, exh_b, tmo_a, tmo_b;

    logic [5:0]  mode_o;
    logic [23:0] key_o;
    logic [21:0] att_o;
    logic        busy_o, found_o, exh_o, tmo_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    key_search_controller #(
        .RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3), .KEY_BITS(22),
        .KEY_START(0), .KEY_STRIDE(1), .TIMEOUT(32)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort),
        .finish_bus(finish_bus), .success(success), .mode(mode_a), .key(key_a),
        .attempts(att_a), .busy(busy_a), .found(found_a), .exhausted(exh_a),
        .timeout_err(tmo_a)
    );

    key_search_controller #(
        .RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3), .KEY_BITS(4),
        .KEY_START(1), .KEY_STRIDE(4), .TIMEOUT(16)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .abort(abort),
        .finish_bus(finish_bus), .success(success), .mode(mode_b), .key(key_b),
        .attempts(att_b), .busy(busy_b), .found(found_b), .exhausted(exh_b),
        .timeout_err(tmo_b)
    );

    always_comb begin
        if (sel) begin
            mode_o = mode_b; key_o = {key_b[0], key_b[1], key_b[2]}; att_o = 22'(att_b);
            busy_o = busy_b; found_o = found_b; exh_o = exh_b; tmo_o = tmo_b;
        end else begin
            mode_o = mode_a; key_o = {key_a[0], key_a[1], key_a[2]}; att_o = att_a;
            busy_o = busy_a; found_o = found_a; exh_o = exh_a; tmo_o = tmo_a;
        end
    end

    function automatic longint cfg_start(bit s);  return s ? 1  : 0;  endfunction
    function automatic longint cfg_stride(bit s); return s ? 4  : 1;  endfunction
    function automatic int     cfg_bits(bit s);   return s ? 4  : 22; endfunction
    function automatic int     cfg_tmo(bit s);    return s ? 16 : 32; endfunction

    function automatic logic [5:0] phase_mode(int p);
        return (p == 0) ? M_INIT : (p == 1) ? M_SHUF : M_DEC;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    bit         exp_found, exp_exh, exp_tmo;
    longint     exp_key;
    int         exp_att;

    // Device model state
    int         cnt;
    logic [5:0] last_m;

    // Walks candidates phase by phase: GAP cycle, then 'lat' cycles of the
    // phase (or TIMEOUT cycles if the device never answers), then outcome.
    task automatic build_model(input bit s, input int lat, input longint hit_key,
                               input longint stuck_key, input int stuck_phase);
        longint k, maxk;
        int     tmo;
        bit     fin;
        exp_q.delete();
        k = cfg_start(s);
        maxk = (longint'(1) << cfg_bits(s)) - 1;
        tmo = cfg_tmo(s);
        exp_found = 0; exp_exh = 0; exp_tmo = 0; exp_att = 0; fin = 0;
        while (!fin) begin
            for (int p = 0; p < 3 && !fin; p++) begin
                exp_q.push_back({1'b1, M_IDLE});
                if ((k == stuck_key && p == stuck_phase) || lat > tmo) begin
                    repeat (tmo) exp_q.push_back({1'b1, phase_mode(p)});
                    exp_tmo = 1; fin = 1;
                end else begin
                    repeat (lat) exp_q.push_back({1'b1, phase_mode(p)});
                    if (p == 2) begin
                        exp_att++;
                        if (k == hit_key) begin
                            exp_found = 1; fin = 1;
                        end else if (k + cfg_stride(s) > maxk) begin
                            exp_exh = 1; fin = 1;
                        end else begin
                            k += cfg_stride(s);
                        end
                    end
                end
            end
        end
        exp_q.push_back({1'b0, M_IDLE});
        exp_key = k;
    endtask

    // Called at a negedge: drives the device responses for the next edge.
    task automatic drive_step(input int lat, input longint stuck_key,
                              input int stuck_phase, input longint hit_key);
        int         p;
        logic [2:0] fb;
        p = (mode_o == M_INIT) ? 0 : (mode_o == M_SHUF) ? 1 : (mode_o == M_DEC) ? 2 : -1;
        if (mode_o != last_m) cnt = 0;
        last_m  = mode_o;
        fb      = 3'($urandom);
        success = 1'($urandom);
        start   = ($urandom_range(0, 15) == 0);
        if (p >= 0) begin
            cnt++;
            fb[p] = (cnt >= lat) && !(longint'(key_o) == stuck_key && p == stuck_phase);
            if (p == 2 && fb[2]) success = (longint'(key_o) == hit_key);
        end
        finish_bus = fb;
    endtask

    task automatic pulse_start(input bit s);
        sel = s;
        @(negedge clk);
        start = 1'b1; finish_bus = '0; success = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; last_m = 6'h3f;
    endtask

    task automatic run_search(input string tag, input bit s, input int lat, input longint hit_key,
                              input longint stuck_key, input int stuck_phase);
        bit done;
        int f0;
        build_model(s, lat, hit_key, stuck_key, stuck_phase);
        pulse_start(s);
        obs_q.delete();
        done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            obs_q.push_back({busy_o, mode_o});
            if (!busy_o) begin
                done = 1; start = 1'b0; finish_bus = '0; success = 1'b0;
            end else begin
                drive_step(lat, stuck_key, stuck_phase, hit_key);
                @(negedge clk);
            end
        end
        check({tag, ":terminated"}, 64'(done), 64'd1);
        check({tag, ":trace_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            f0 = n_fail;
            check($sformatf("%s:trace[%0d]", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
            if (n_fail != f0) break;
        end
        check({tag, ":found"},     64'(found_o), 64'(exp_found));
        check({tag, ":exhausted"}, 64'(exh_o),   64'(exp_exh));
        check({tag, ":timeout"},   64'(tmo_o),   64'(exp_tmo));
        check({tag, ":key"},       64'(key_o),   64'(exp_key));
        check({tag, ":attempts"},  64'(att_o),   64'(exp_att));
        repeat (3) @(negedge clk);
        check({tag, ":sticky"}, 64'({found_o, exh_o, tmo_o, busy_o}),
              64'({exp_found, exp_exh, exp_tmo, 1'b0}));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":mode"},  64'(mode_o), 64'(M_IDLE));
        check({tag, ":key"},   64'(key_o),  64'd0);
        check({tag, ":att"},   64'(att_o),  64'd0);
        check({tag, ":flags"}, 64'({busy_o, found_o, exh_o, tmo_o}), 64'd0);
    endtask

    initial begin
        bit     s;
        int     lat, j, kind, sp;
        longint hk, sk;

        reset = 1'b1; start = 1'b0; abort = 1'b0; success = 1'b0;
        finish_bus = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_a");
        sel = 1'b1; #1;
        check_all_zero("reset_b");
        reset = 1'b0;

        // Immediate hit on the first candidate.
        run_search("imm_hit", 1'b0, 5, 0, -1, -1);
        // Abort from FOUND clears the sticky flag.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_found:found", 64'(found_o), 64'd0);
        check("abort_found:busy",  64'(busy_o),  64'd0);

        run_search("hit_k3",    1'b0, $urandom_range(1, 12), 3, -1, -1);
        run_search("exhaust",   1'b1, 5, -1, -1, -1);
        run_search("tmo_shuf",  1'b1, 5, -1, 1, 1);
        run_search("tmo_bound", 1'b1, 16, 9, -1, -1);

        // Cross-talk and abort during SHUFFLE.
        pulse_start(1'b1);
        for (int c = 0; c < 200 && mode_o != M_SHUF; c++) begin
            drive_step(5, -1, -1, -1);
            @(negedge clk);
        end
        check("abort:reach_shuffle", 64'(mode_o), 64'(M_SHUF));
        start = 1'b0; finish_bus = 3'b101; success = 1'b1;
        @(negedge clk);
        check("xtalk:mode", 64'(mode_o), 64'(M_SHUF));
        check("xtalk:busy", 64'(busy_o), 64'd1);
        finish_bus = '0; success = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort:mode", 64'(mode_o), 64'(M_IDLE));
        check("abort:flags", 64'({busy_o, found_o, exh_o, tmo_o}), 64'd0);
        run_search("after_abort", 1'b1, 3, -1, -1, -1);

        // Asynchronous reset during the second candidate's DECRYPT.
        pulse_start(1'b0);
        for (int c = 0; c < 400 && !(mode_o == M_DEC && key_o == 24'd1); c++) begin
            drive_step(6, -1, -1, 5);
            @(negedge clk);
        end
        check("rst:reach_decrypt", 64'({mode_o, key_o}), 64'({M_DEC, 24'd1}));
        reset = 1'b1; start = 1'b0; finish_bus = '0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        run_search("after_rst", 1'b0, 4, 2, -1, -1);

        // Randomised searches.
        for (int r = 0; r < 8; r++) begin
            s    = 1'($urandom_range(0, 1));
            lat  = ($urandom_range(0, 4) == 0) ? cfg_tmo(s) + 2 : $urandom_range(1, cfg_tmo(s));
            j    = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            hk = -1; sk = -1; sp = -1;
            if (kind == 1) begin
                sk = cfg_start(s) + longint'(j) * cfg_stride(s);
                sp = $urandom_range(0, 2);
            end else if (kind == 0 || !s) begin
                hk = cfg_start(s) + longint'(j) * cfg_stride(s);
            end
            run_search($sformatf("rand%0d", r), s, lat, hk, sk, sp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
